// File: rtl/fade_mixer.sv
// Output-side fade mixer: blends each pixel toward its inverse with a per-frame alpha ramp.
// Optional ordered-dither rounding is enabled by defining FADE_DITHER_EN.
module fade_mixer #(
    parameter int STEP = 32,
    parameter int AW   = 9
) (
    input  logic        vout_clk_i,
    input  logic        rst_n,
    input  logic        hs_i,
    input  logic        vs_i,
    input  logic        de_i,
    input  logic [23:0] data_i,
    input  logic        px_inv_i,
    input  logic        restart_i,
    input  logic        bypass_i,
    output logic        hs_o,
    output logic        vs_o,
    output logic        de_o,
    output logic [23:0] data_o,
    output logic        fading_o
);

    localparam logic [AW-1:0] A_FULL = AW'(256);

    function automatic logic [AW-1:0] sat_alpha(input logic [AW:0] s);
        return (s > (AW+1)'(256)) ? A_FULL : s[AW-1:0];
    endfunction

    function automatic logic [15:0] mix_chan(input logic [7:0] c, input logic [AW-1:0] a);
        logic [15:0] w_c;
        logic [15:0] w_n;
        w_c = 16'(c) * (16'd256 - 16'(a));
        w_n = 16'(8'd255 - c) * 16'(a);
        return w_c + w_n;
    endfunction

    function automatic logic [7:0] round_chan(input logic [15:0] m, input logic [7:0] r);
        logic [16:0] s;
        s = {1'b0, m} + 17'(r);
        return s[15:8];
    endfunction

    logic          vs_r;
    logic          tick;
    logic [AW-1:0] alpha, alpha_nxt;
    logic          pending, pending_nxt;

    assign tick = vs_i & ~vs_r;

    // A restart landing on the tick itself is consumed immediately.
    always_comb begin
        alpha_nxt   = alpha;
        pending_nxt = pending;
        if (tick) begin
            pending_nxt = 1'b0;
            alpha_nxt   = (pending || restart_i) ? '0
                        : sat_alpha({1'b0, alpha} + (AW+1)'(STEP));
        end else if (restart_i) begin
            pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge vout_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            vs_r     <= 1'b0;
            alpha    <= A_FULL;
            pending  <= 1'b0;
            fading_o <= 1'b0;
        end else begin
            vs_r     <= vs_i;
            alpha    <= alpha_nxt;
            pending  <= pending_nxt;
            fading_o <= (alpha_nxt != A_FULL);
        end
    end

    logic [23:0]      d_p1, d_p2;
    logic [2:0]       sync_p1, sync_p2;
    logic             inv_p1, inv_p2;
    logic [AW-1:0]    a_p1;
    logic [2:0][15:0] m_p2;
    logic [7:0]       rnd;

`ifdef FADE_DITHER_EN
    logic de_r, x_bit, y_bit, x_cur;
    logic [1:0] par_p1, par_p2;
    logic exact_p2;

    assign x_cur = (de_i & ~de_r) ? 1'b0 : x_bit;

    always_ff @(posedge vout_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            de_r     <= 1'b0;
            x_bit    <= 1'b0;
            y_bit    <= 1'b0;
            par_p1   <= '0;
            par_p2   <= '0;
            exact_p2 <= 1'b0;
        end else begin
            de_r     <= de_i;
            x_bit    <= de_i ? ~x_cur : x_bit;
            y_bit    <= tick ? 1'b0 : ((de_r & ~de_i) ? ~y_bit : y_bit);
            par_p1   <= {y_bit, x_cur};
            par_p2   <= par_p1;
            exact_p2 <= (a_p1 == '0) || (a_p1 == A_FULL);
        end
    end

    // Endpoint alphas keep the plain rounding so a=0 and a=256 stay exact.
    always_comb begin
        rnd = 8'd128;
        if (!exact_p2) begin
            case (par_p2)
                2'b00:   rnd = 8'd32;
                2'b01:   rnd = 8'd160;
                2'b10:   rnd = 8'd224;
                default: rnd = 8'd96;
            endcase
        end
    end
`else
    assign rnd = 8'd128;
`endif

    always_ff @(posedge vout_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            d_p1    <= '0;
            sync_p1 <= '0;
            inv_p1  <= 1'b0;
            a_p1    <= '0;
            d_p2    <= '0;
            sync_p2 <= '0;
            inv_p2  <= 1'b0;
            m_p2    <= '0;
            data_o  <= '0;
            hs_o    <= 1'b0;
            vs_o    <= 1'b0;
            de_o    <= 1'b0;
        end else begin
            // S1: capture pixel, sync, effective invert flag and the frame's alpha
            d_p1    <= data_i;
            sync_p1 <= {hs_i, vs_i, de_i};
            inv_p1  <= px_inv_i & ~bypass_i;
            a_p1    <= alpha;
            // S2: blend products per channel
            d_p2    <= d_p1;
            sync_p2 <= sync_p1;
            inv_p2  <= inv_p1;
            for (int i = 0; i < 3; i++) begin
                m_p2[i] <= mix_chan(d_p1[i*8 +: 8], a_p1);
            end
            // S3: round or pass through
            {hs_o, vs_o, de_o} <= sync_p2;
            for (int i = 0; i < 3; i++) begin
                data_o[i*8 +: 8] <= inv_p2 ? round_chan(m_p2[i], rnd) : d_p2[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_fade_mixer.sv
// Randomized bench for fade_mixer against a frame-level alpha/blend reference model.
module tb_fade_mixer;

    localparam int STEP = 32;

    logic        vout_clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        hs_i = 1'b0, vs_i = 1'b0, de_i = 1'b0;
    logic [23:0] data_i = '0;
    logic        px_inv_i = 1'b0, restart_i = 1'b0, bypass_i = 1'b0;
    logic        hs_o, vs_o, de_o, fading_o;
    logic [23:0] data_o;

    fade_mixer #(.STEP(STEP), .AW(9)) dut (
        .vout_clk_i(vout_clk_i), .rst_n(rst_n),
        .hs_i(hs_i), .vs_i(vs_i), .de_i(de_i), .data_i(data_i),
        .px_inv_i(px_inv_i), .restart_i(restart_i), .bypass_i(bypass_i),
        .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .data_o(data_o), .fading_o(fading_o)
    );

    always #5 vout_clk_i = ~vout_clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: alpha per frame, pending restart, previous vs/de, dither parities.
    int          m_alpha = 256;
    bit          m_pending = 0;
    bit          m_vs = 0, m_de = 0;
    bit          m_x = 0, m_y = 0;
    logic [26:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int blend(input int c, input int a, input bit inv, input int r);
        if (!inv) return c;
        return (c * (256 - a) + (255 - c) * a + r) / 256;
    endfunction

    task automatic model_reset();
        m_alpha = 256; m_pending = 0; m_vs = 0; m_de = 0; m_x = 0; m_y = 0;
        exp_q = {27'd0, 27'd0, 27'd0};
    endtask

    task automatic step(input bit hs, input bit vs, input bit de, input logic [23:0] d,
                        input bit inv, input bit rs, input bit byp);
        logic [26:0] e;
        logic [23:0] pix;
        bit tick, xc;
        int r;
        @(negedge vout_clk_i);
        e = exp_q.pop_front();
        check("sync", {29'd0, hs_o, vs_o, de_o}, {29'd0, e[26:24]});
        check("data", {8'd0, data_o}, {8'd0, e[23:0]});
        check("fading", {31'd0, fading_o}, {31'd0, (m_alpha != 256)});
        hs_i = hs; vs_i = vs; de_i = de; data_i = d;
        px_inv_i = inv; restart_i = rs; bypass_i = byp;
        tick = vs & ~m_vs;
        xc = (de & ~m_de) ? 1'b0 : m_x;
        r = 128;
`ifdef FADE_DITHER_EN
        if (m_alpha != 0 && m_alpha != 256)
            r = ({m_y, xc} == 2'b00) ? 32 : ({m_y, xc} == 2'b01) ? 160 :
                ({m_y, xc} == 2'b10) ? 224 : 96;
`endif
        for (int i = 0; i < 3; i++)
            pix[i*8 +: 8] = 8'(blend(int'(d[i*8 +: 8]), m_alpha, inv & ~byp, r));
        exp_q.push_back({hs, vs, de, pix});
        if (tick) begin
            m_alpha   = (m_pending || rs) ? 0 : ((m_alpha + STEP > 256) ? 256 : m_alpha + STEP);
            m_pending = 0;
        end else if (rs) begin
            m_pending = 1;
        end
        m_y  = tick ? 1'b0 : ((m_de & ~de) ? ~m_y : m_y);
        m_x  = de ? ~xc : m_x;
        m_de = de;
        m_vs = vs;
    endtask

    task automatic do_reset();
        @(negedge vout_clk_i);
        rst_n = 1'b0;
        #1;
        check("rst_out", {5'd0, hs_o, vs_o, de_o, data_o}, 32'd0);
        check("rst_fading", {31'd0, fading_o}, 32'd0);
        hs_i = 0; vs_i = 0; de_i = 0; data_i = '0;
        px_inv_i = 0; restart_i = 0; bypass_i = 0;
        @(negedge vout_clk_i);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [23:0] rand_pix();
        case ($urandom_range(0, 5))
            0:       return 24'h000000;
            1:       return 24'hFFFFFF;
            2:       return 24'h102030;
            3:       return 24'h808080;
            default: return 24'($urandom);
        endcase
    endfunction

    // One frame: 2-cycle vsync, three 6-pixel lines; restarts at the given cycles.
    task automatic run_frame(input int rs_a, input int rs_b, input int rs_c);
        for (int c = 0; c < 32; c++) begin
            bit de;
            de = (c >= 4) && (c < 31) && (((c - 4) % 9) < 6);
            step(((c - 4) % 9) == 7, c < 2, de, rand_pix(), 1'($urandom),
                 (c == rs_a) || (c == rs_b) || (c == rs_c), ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        #2;
        check("rst_out", {5'd0, hs_o, vs_o, de_o, data_o}, 32'd0);
        check("rst_fading", {31'd0, fading_o}, 32'd0);
        #20;
        @(negedge vout_clk_i);
        rst_n = 1'b1;
        model_reset();
        for (int f = 0; f < 2; f++) run_frame(-1, -1, -1);
        run_frame(15, -1, -1);
        for (int f = 0; f < 11; f++) run_frame(-1, -1, -1);
        run_frame(0, -1, -1);
        for (int f = 0; f < 10; f++) run_frame(-1, -1, -1);
        run_frame(6, 12, 20);
        for (int f = 0; f < 3; f++) run_frame(-1, -1, -1);
        do_reset();
        for (int f = 0; f < 2; f++) run_frame(-1, -1, -1);
        run_frame(1, 9, -1);
        for (int f = 0; f < 4; f++) run_frame(-1, -1, -1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 24'h0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
